// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: hex glyph table,
// slot state encoding and segment bit range.
package seg7_pkg;

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_DRIVE = 1'b1;

  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  // Active-high glyphs {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high segment pattern; output polarity is the parent's job.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]           nib_i,
  output logic [SEG_G:SEG_A]   seg_o
);

  assign seg_o = hex2seg(nib_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed hex display scanner with blank interval, leading-zero
// suppression, digit mask and frame-aligned double-buffered updates.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICK_DIV        = 65536,
  parameter int BLANK_CYCLES    = 256,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int DIG_ACTIVE_HIGH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   ground,
  output logic [6:0]              display,
  output logic                    dp,
  output logic                    frame_tick,
  output logic                    update_done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] GND_OFF =
    (DIG_ACTIVE_HIGH != 0) ? {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, pend_data_q;
  logic [NUM_DIGITS-1:0]   act_dp_q, pend_dp_q;
  logic                    pend_vld_q;
  logic [NUM_DIGITS-1:0]   ground_q, ground_d;
  logic [6:0]              display_q, display_d;
  logic                    dp_q, dp_d;
  logic                    frame_tick_q, update_done_q;

  logic                  slot_end, wrap, state, lit;
  logic [NUM_DIGITS-1:0] lz_sup, gnd_hot;
  logic [3:0]            cur_nib;
  logic [6:0]            seg_raw;

  assign slot_end = (cnt_q == CNT_LAST);
  assign wrap     = slot_end && (idx_q == IDX_LAST);
  assign cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
  assign idx_d    = !slot_end ? idx_q : (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign state    = (cnt_q < BLANK_END) ? ST_BLANK : ST_DRIVE;

  // A digit is a leading zero when it and every more-significant nibble are zero.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
    if (g == 0) begin : g_lsd
      assign lz_sup[g] = 1'b0;
    end else begin : g_upper
      assign lz_sup[g] = blank_lz && (act_data_q[4*NUM_DIGITS-1:4*g] == '0);
    end
  end

  assign cur_nib = act_data_q[{idx_q, 2'b00} +: 4];
  assign lit     = (state == ST_DRIVE) && dig_en[idx_q] && !lz_sup[idx_q];

  seg7_decode u_dec (
    .nib_i (cur_nib),
    .seg_o (seg_raw)
  );

  always_comb begin
    gnd_hot        = '0;
    gnd_hot[idx_q] = lit;
    ground_d       = gnd_hot ^ GND_OFF;
    display_d      = (lit ? seg_raw : 7'h00) ^ SEG_OFF;
    dp_d           = (lit & act_dp_q[idx_q]) ^ DP_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_vld_q    <= 1'b0;
      ground_q      <= GND_OFF;
      display_q     <= SEG_OFF;
      dp_q          <= DP_OFF;
      frame_tick_q  <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      ground_q      <= ground_d;
      display_q     <= display_d;
      dp_q          <= dp_d;
      frame_tick_q  <= wrap;
      update_done_q <= wrap && pend_vld_q;
      // The commit reads the old pending copy, so a load landing on the wrap
      // cycle simply becomes the next frame's pending data.
      if (wrap && pend_vld_q) begin
        act_data_q <= pend_data_q;
        act_dp_q   <= pend_dp_q;
      end
      if (load) begin
        pend_data_q <= data_in;
        pend_dp_q   <= dp_in;
        pend_vld_q  <= 1'b1;
      end else if (wrap) begin
        pend_vld_q  <= 1'b0;
      end
    end
  end

  assign ground      = ground_q;
  assign display     = display_q;
  assign dp          = dp_q;
  assign frame_tick  = frame_tick_q;
  assign update_done = update_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Frame-level scoreboard bench for seg7_scan_ctrl (4 digits, 8-cycle slots).
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int TD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in;
  logic [3:0]  dp_in, dig_en;
  logic        load, blank_lz;
  logic [3:0]  ground;
  logic [6:0]  display;
  logic        dp, frame_tick, update_done;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpm;
    logic [3:0]  en;
    logic        lz;
    logic        upd;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_HIGH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
    .dig_en(dig_en), .blank_lz(blank_lz), .ground(ground), .display(display),
    .dp(dp), .frame_tick(frame_tick), .update_done(update_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Expected {ground, display, dp} for slot s of a frame; active-low segments.
  function automatic logic [11:0] pins(input frame_t r, input int s, input bit drv);
    logic       lit;
    logic [3:0] nib;
    logic [3:0] g;
    nib = r.data[4*s +: 4];
    lit = drv && r.en[s] && !(r.lz && s > 0 && (r.data >> (4*s)) == 16'h0);
    g   = lit ? (4'b0001 << s) : 4'b0000;
    return {g, lit ? ~SEG[nib] : 7'h7F, ~(lit & r.dpm[s])};
  endfunction

  task automatic wait_tick();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (frame_tick) return;
    end
    chk("tick_timeout", frame_tick, 1);
  endtask

  task automatic push_rec(input logic [15:0] d, input logic [3:0] dpm,
                          input logic [3:0] en, input logic lz, input logic upd);
    frame_t r;
    #1;
    r.data = d; r.dpm = dpm; r.en = en; r.lz = lz; r.upd = upd;
    exp_q.push_back(r);
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] dpm);
    data_in = d;
    dp_in   = dpm;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Monitor: each frame_tick with a queued record checks the frame that follows.
  initial begin : mon
    frame_t r;
    forever begin
      @(negedge clk);
      while (frame_tick && exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("update_done", update_done, r.upd);
        for (int s = 0; s < ND; s++) begin
          for (int c = 0; c < TD; c++) begin
            @(negedge clk);
            if (c == 1)
              chk($sformatf("blank_s%0d", s), {ground, display, dp}, pins(r, s, 0));
            else if (c == BC || c == TD - 1)
              chk($sformatf("drive_s%0d_c%0d", s, c), {ground, display, dp}, pins(r, s, 1));
            else if (c == 4)
              chk("pulse_low", {frame_tick, update_done}, 2'b00);
          end
        end
      end
    end
  end

  initial begin
    load = 1'b0; data_in = '0; dp_in = '0; dig_en = 4'hF; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pins", {ground, display, dp}, 12'h0FF);
    chk("rst_pulses", {frame_tick, update_done}, 2'b00);
    rst_n = 1'b1;
    @(negedge clk); chk("post_rst_c0", {ground, display, dp}, 12'h0FF);
    @(negedge clk); chk("post_rst_c1", {ground, display, dp}, 12'h0FF);
    @(negedge clk); chk("first_drive", {ground, display, dp}, {4'b0001, 7'h40, 1'b1});
    drive_load(16'h9999, 4'hF);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("async_rst", {ground, display, dp}, 12'h0FF);
    chk("async_rst_pulses", {frame_tick, update_done}, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    push_rec(16'h0000, 4'h0, 4'hF, 1'b0, 1'b0);

    wait_tick();
    push_rec(16'h1234, 4'b0010, 4'hF, 1'b0, 1'b1);
    drive_load(16'h1234, 4'b0010);
    wait_tick();
    push_rec(16'h1234, 4'b0010, 4'hF, 1'b0, 1'b0);
    wait_tick();
    push_rec(16'hAAAA, 4'h0, 4'hF, 1'b0, 1'b1);
    repeat (11) @(negedge clk);
    drive_load(16'hAAAA, 4'h0);
    wait_tick();
    push_rec(16'hAAAA, 4'h0, 4'hF, 1'b0, 1'b0);

    wait_tick();
    push_rec(16'h1111, 4'h0, 4'hF, 1'b0, 1'b1);
    drive_load(16'h1111, 4'h0);
    repeat (30) @(negedge clk);
    drive_load(16'h2222, 4'h0);
    chk("collision_tick", frame_tick, 1);
    push_rec(16'h2222, 4'h0, 4'hF, 1'b0, 1'b1);

    wait_tick();
    push_rec(16'h0050, 4'h0, 4'hF, 1'b1, 1'b1);
    drive_load(16'h0050, 4'h0);
    wait_tick();
    blank_lz = 1'b1;
    push_rec(16'h0000, 4'h0, 4'hF, 1'b1, 1'b1);
    drive_load(16'h0000, 4'h0);
    wait_tick();
    push_rec(16'hFFFF, 4'hF, 4'b0101, 1'b0, 1'b1);
    drive_load(16'hFFFF, 4'hF);
    wait_tick();
    blank_lz = 1'b0;
    dig_en   = 4'b0101;
    push_rec(16'hFFFF, 4'hF, 4'b0101, 1'b0, 1'b0);
    wait_tick();
    wait_tick();
    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
